otter_ir_pipeline: RTL

Instruction-register pipeline for the pipelined OTTER core. It carries each fetched instruction and its PC through the DEC, EXE, MEM and WB stages and presents the four stage IRs to the control decoder. It also detects load-use hazards and stalls fetch when one occurs. When the decoder reports a taken branch or jump, it squashes the wrong-path instructions.

---
 rtl/otter_pkg.sv | 31 +++
 rtl/otter_hazard_detect.sv | 57 +++++
 rtl/otter_ir_pipeline.sv | 92 +++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: RV32I opcodes, the bubble encoding and
// instruction field positions used by the pipeline and control decoder.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;

    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 7;
    localparam int FUNC3_MSB  = 14;
    localparam int FUNC3_LSB  = 12;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int RS2_MSB    = 24;
    localparam int RS2_LSB    = 20;

endpackage

// File: rtl/otter_hazard_detect.sv
// Load-use hazard detector: flags a DEC instruction that reads the register
// a LOAD currently in EXE is about to write.
module otter_hazard_detect
    import otter_pkg::*;
(
    input  logic [31:0] dec_ir,
    input  logic        dec_valid,
    input  logic [31:0] exe_ir,
    input  logic        exe_valid,
    output logic        hazard
);

    logic [6:0] dec_opcode;
    logic [2:0] dec_func3;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [6:0] exe_opcode;
    logic [4:0] exe_rd;
    logic       reads_rs1;
    logic       reads_rs2;
    logic       exe_is_load;
    logic       unused_bits;

    assign dec_opcode  = dec_ir[OPCODE_MSB:OPCODE_LSB];
    assign dec_func3   = dec_ir[FUNC3_MSB:FUNC3_LSB];
    assign dec_rs1     = dec_ir[RS1_MSB:RS1_LSB];
    assign dec_rs2     = dec_ir[RS2_MSB:RS2_LSB];
    assign exe_opcode  = exe_ir[OPCODE_MSB:OPCODE_LSB];
    assign exe_rd      = exe_ir[RD_MSB:RD_LSB];
    assign exe_is_load = (exe_opcode == LOAD);
    assign unused_bits = ^{dec_ir[31:25], dec_ir[11:7], exe_ir[31:12]};

    // Only real register reads count; immediates that happen to sit in the
    // rs1/rs2 bit positions (LUI, AUIPC, JAL) must not cause a stall.
    always_comb begin
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        case (dec_opcode)
            JALR, LOAD, OP_IMM: reads_rs1 = 1'b1;
            BRANCH, STORE, OP: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            SYSTEM: reads_rs1 = (dec_func3 == 3'd1) || (dec_func3 == 3'd2)
                                || (dec_func3 == 3'd3);
            default: begin
                reads_rs1 = 1'b0;
                reads_rs2 = 1'b0;
            end
        endcase
    end

    assign hazard = exe_valid && exe_is_load && (exe_rd != 5'd0) && dec_valid
                    && ((reads_rs1 && (dec_rs1 == exe_rd))
                        || (reads_rs2 && (dec_rs2 == exe_rd)));

endmodule

// File: rtl/otter_ir_pipeline.sv
// Instruction-register pipeline for the pipelined OTTER: carries IR/PC/valid
// through DEC, EXE, MEM and WB, stalls on load-use and squashes on flush.
module otter_ir_pipeline
    import otter_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter logic [31:0] PC_RESET  = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IF_IR,
    input  logic [31:0] IF_PC,
    input  logic        IF_VALID,
    input  logic        FLUSH,
    output logic [31:0] DEC_IR,
    output logic [31:0] EXE_IR,
    output logic [31:0] MEM_IR,
    output logic [31:0] WB_IR,
    output logic [31:0] DEC_PC,
    output logic [31:0] EXE_PC,
    output logic        DEC_VALID,
    output logic        EXE_VALID,
    output logic        MEM_VALID,
    output logic        WB_VALID,
    output logic        STALL,
    output logic [31:0] RETIRE_CNT,
    output logic [31:0] STALL_CNT
);

    logic hazard;

    otter_hazard_detect u_hazard_detect (
        .dec_ir    (DEC_IR),
        .dec_valid (DEC_VALID),
        .exe_ir    (EXE_IR),
        .exe_valid (EXE_VALID),
        .hazard    (hazard)
    );

    // A flush discards DEC anyway, so holding it for a hazard would be pointless.
    assign STALL = hazard && !FLUSH;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DEC_IR     <= NOP_INSTR;
            EXE_IR     <= NOP_INSTR;
            MEM_IR     <= NOP_INSTR;
            WB_IR      <= NOP_INSTR;
            DEC_PC     <= PC_RESET;
            EXE_PC     <= PC_RESET;
            DEC_VALID  <= 1'b0;
            EXE_VALID  <= 1'b0;
            MEM_VALID  <= 1'b0;
            WB_VALID   <= 1'b0;
            RETIRE_CNT <= 32'd0;
            STALL_CNT  <= 32'd0;
        end else begin
            if (WB_VALID) begin
                RETIRE_CNT <= RETIRE_CNT + 32'd1;
            end
            if (STALL) begin
                STALL_CNT <= STALL_CNT + 32'd1;
            end

            MEM_IR    <= EXE_IR;
            MEM_VALID <= EXE_VALID;
            WB_IR     <= MEM_IR;
            WB_VALID  <= MEM_VALID;

            if (FLUSH) begin
                DEC_IR    <= NOP_INSTR;
                DEC_VALID <= 1'b0;
                DEC_PC    <= IF_PC;
                EXE_IR    <= NOP_INSTR;
                EXE_VALID <= 1'b0;
                EXE_PC    <= DEC_PC;
            end else if (STALL) begin
                EXE_IR    <= NOP_INSTR;
                EXE_VALID <= 1'b0;
                EXE_PC    <= DEC_PC;
            end else begin
                DEC_IR    <= IF_VALID ? IF_IR : NOP_INSTR;
                DEC_VALID <= IF_VALID;
                DEC_PC    <= IF_PC;
                EXE_IR    <= DEC_IR;
                EXE_VALID <= DEC_VALID;
                EXE_PC    <= DEC_PC;
            end
        end
    end

endmodule
